fp_round_scheduler: RTL and testbench

FP_ROUND_SCHEDULER -- requirements
Module: fp_round_scheduler

---
 rtl/fp_round_scheduler_if.sv | 52 +++++
 rtl/fp_round_scheduler.sv | 158 +++++++++++++++
 tb/tb_fp_round_scheduler.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_round_scheduler_if.sv
// Request/response bundle for the shared rounding scheduler: two requesters,
// each with an operand channel (req) and a result channel (rsp).
interface fp_round_scheduler_if #(
  parameter int N = 24,
  parameter int E = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_mant;
  logic [E-1:0] req0_exp;
  logic         req0_R;
  logic         req0_S;

  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_mant;
  logic [E-1:0] req1_exp;
  logic         req1_R;
  logic         req1_S;

  logic         rsp0_valid;
  logic         rsp0_ready;
  logic [N-1:0] rsp0_mant;
  logic [E-1:0] rsp0_exp;
  logic         rsp0_inexact;
  logic         rsp0_ovf;

  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [N-1:0] rsp1_mant;
  logic [E-1:0] rsp1_exp;
  logic         rsp1_inexact;
  logic         rsp1_ovf;

  modport master (
    output req0_valid, req0_mant, req0_exp, req0_R, req0_S,
    output req1_valid, req1_mant, req1_exp, req1_R, req1_S,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_mant, rsp0_exp, rsp0_inexact, rsp0_ovf,
    input  rsp1_valid, rsp1_mant, rsp1_exp, rsp1_inexact, rsp1_ovf,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_mant, req0_exp, req0_R, req0_S,
    input  req1_valid, req1_mant, req1_exp, req1_R, req1_S,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_mant, rsp0_exp, rsp0_inexact, rsp0_ovf,
    output rsp1_valid, rsp1_mant, rsp1_exp, rsp1_inexact, rsp1_ovf,
    input  rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/fp_round_scheduler.sv
// Round-robin scheduler sharing one round-to-nearest-even datapath between
// two requesters; one operation in flight, accept -> response in 2 cycles.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | arbitrating; ready asserted for the granted requester only
//   ROUND | captured operand is rounded; result registered on exit
//   RESP  | result held for the granted requester until it is consumed
module fp_round_scheduler #(
  parameter int N = 24,
  parameter int E = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  fp_round_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [E-1:0] EXP_MAX    = {E{1'b1}};
  localparam logic [E-1:0] EXP_SAT    = {{(E-1){1'b1}}, 1'b0};
  localparam logic [E-1:0] EXP_ONE    = {{(E-1){1'b0}}, 1'b1};
  localparam logic [N:0]   MANT_ONE   = {{N{1'b0}}, 1'b1};
  localparam logic [N-1:0] MANT_CARRY = {1'b1, {(N-1){1'b0}}};

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_last_grant;
  logic         r_grant;
  logic [N-1:0] r_mant;
  logic [E-1:0] r_exp;
  logic         r_R;
  logic         r_S;

  logic         r_rsp_valid;
  logic [N-1:0] r_res_mant;
  logic [E-1:0] r_res_exp;
  logic         r_res_inexact;
  logic         r_res_ovf;

  logic         w_any_valid;
  logic         w_sel;
  logic         w_accept;
  logic         w_rsp_ready_g;
  logic         w_rsp_fire;

  logic         w_round_up;
  logic [N:0]   w_sum;
  logic [N-1:0] w_res_mant;
  logic [E-1:0] w_res_exp;
  logic         w_res_inexact;
  logic         w_res_ovf;

  // A lone requester wins outright; on a tie the one not granted last wins.
  always_comb begin
    w_any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      w_sel = ~r_last_grant;
    end else begin
      w_sel = bus.req1_valid;
    end
    w_accept = (r_state == IDLE) && w_any_valid;
  end

  assign bus.req0_ready = w_accept & ~w_sel;
  assign bus.req1_ready = w_accept &  w_sel;

  assign w_rsp_ready_g = r_grant ? bus.rsp1_ready : bus.rsp0_ready;
  assign w_rsp_fire    = r_rsp_valid & w_rsp_ready_g;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ROUND;
      ROUND:   w_state_nxt = RESP;
      RESP:    if (w_rsp_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Carry-out of the increment renormalises to 1.000...; carrying into the
  // top exponent code (or beyond) saturates to the all-ones overflow encoding.
  always_comb begin
    w_round_up    = r_R & (r_S | r_mant[0]);
    w_sum         = {1'b0, r_mant} + MANT_ONE;
    w_res_mant    = r_mant;
    w_res_exp     = r_exp;
    w_res_ovf     = 1'b0;
    w_res_inexact = r_R | r_S;
    if (w_round_up) begin
      if (w_sum[N]) begin
        if (r_exp >= EXP_SAT) begin
          w_res_mant = '0;
          w_res_exp  = EXP_MAX;
          w_res_ovf  = 1'b1;
        end else begin
          w_res_mant = MANT_CARRY;
          w_res_exp  = r_exp + EXP_ONE;
        end
      end else begin
        w_res_mant = w_sum[N-1:0];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_last_grant  <= 1'b1;
      r_grant       <= 1'b0;
      r_mant        <= '0;
      r_exp         <= '0;
      r_R           <= 1'b0;
      r_S           <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_res_mant    <= '0;
      r_res_exp     <= '0;
      r_res_inexact <= 1'b0;
      r_res_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
        r_mant       <= w_sel ? bus.req1_mant : bus.req0_mant;
        r_exp        <= w_sel ? bus.req1_exp  : bus.req0_exp;
        r_R          <= w_sel ? bus.req1_R    : bus.req0_R;
        r_S          <= w_sel ? bus.req1_S    : bus.req0_S;
      end
      if (r_state == ROUND) begin
        r_rsp_valid   <= 1'b1;
        r_res_mant    <= w_res_mant;
        r_res_exp     <= w_res_exp;
        r_res_inexact <= w_res_inexact;
        r_res_ovf     <= w_res_ovf;
      end else if (w_rsp_fire) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.rsp0_valid   = r_rsp_valid & ~r_grant;
  assign bus.rsp1_valid   = r_rsp_valid &  r_grant;
  assign bus.rsp0_mant    = r_res_mant;
  assign bus.rsp1_mant    = r_res_mant;
  assign bus.rsp0_exp     = r_res_exp;
  assign bus.rsp1_exp     = r_res_exp;
  assign bus.rsp0_inexact = r_res_inexact;
  assign bus.rsp1_inexact = r_res_inexact;
  assign bus.rsp0_ovf     = r_res_ovf;
  assign bus.rsp1_ovf     = r_res_ovf;

endmodule

// File: tb/tb_fp_round_scheduler.sv
// Directed bench for fp_round_scheduler: a rounding vector table plus
// hand-written tie, round-robin, backpressure and mid-operation reset sequences.
module tb_fp_round_scheduler;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 Clock = ~Clock;

  fp_round_scheduler_if #(.N(24), .E(8)) bus ();

  fp_round_scheduler #(.N(24), .E(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    int          k;
    logic [23:0] mant;
    logic [7:0]  e;
    logic        r;
    logic        s;
    logic [23:0] xm;
    logic [7:0]  xe;
    logic        xi;
    logic        xo;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic drive_req(input int k, input logic v, input logic [23:0] m,
                           input logic [7:0] e, input logic r, input logic s);
    if (k == 0) begin
      bus.req0_valid = v; bus.req0_mant = m; bus.req0_exp = e; bus.req0_R = r; bus.req0_S = s;
    end else begin
      bus.req1_valid = v; bus.req1_mant = m; bus.req1_exp = e; bus.req1_R = r; bus.req1_S = s;
    end
  endtask

  task automatic set_rsp_ready(input int k, input logic v);
    if (k == 0) bus.rsp0_ready = v;
    else        bus.rsp1_ready = v;
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction
  function automatic logic rvld(input int k);
    return (k == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction
  function automatic logic [23:0] rmant(input int k);
    return (k == 0) ? bus.rsp0_mant : bus.rsp1_mant;
  endfunction
  function automatic logic [7:0] rexp(input int k);
    return (k == 0) ? bus.rsp0_exp : bus.rsp1_exp;
  endfunction
  function automatic logic rinx(input int k);
    return (k == 0) ? bus.rsp0_inexact : bus.rsp1_inexact;
  endfunction
  function automatic logic rovf(input int k);
    return (k == 0) ? bus.rsp0_ovf : bus.rsp1_ovf;
  endfunction

  // Called just after a negedge with requester k valid; returns with k ready.
  task automatic wait_ready(input int k, input string name);
    int cnt;
    cnt = 0;
    #1;
    while (!rdy(k) && cnt < 20) begin
      @(negedge Clock); #1;
      cnt++;
    end
    chk({name, " req_ready"}, rdy(k), 1);
  endtask

  task automatic check_result(input int k, input string name, input logic [23:0] xm,
                              input logic [7:0] xe, input logic xi, input logic xo);
    chk({name, " rsp_valid"},       rvld(k),   1);
    chk({name, " other rsp_valid"}, rvld(1-k), 0);
    chk({name, " mant"},            rmant(k),  xm);
    chk({name, " exp"},             rexp(k),   xe);
    chk({name, " inexact"},         rinx(k),   xi);
    chk({name, " ovf"},             rovf(k),   xo);
  endtask

  task automatic run_op(input vec_t v, input string name);
    @(negedge Clock);
    drive_req(v.k, 1'b1, v.mant, v.e, v.r, v.s);
    set_rsp_ready(1 - v.k, 1'b1);
    wait_ready(v.k, name);
    @(posedge Clock);
    @(negedge Clock);
    drive_req(v.k, 1'b0, 24'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    chk({name, " no rsp in ROUND"}, rvld(v.k), 0);
    chk({name, " not ready in ROUND"}, {30'd0, bus.req1_ready, bus.req0_ready}, 0);
    @(negedge Clock);
    check_result(v.k, name, v.xm, v.xe, v.xi, v.xo);
    set_rsp_ready(v.k, 1'b1);
    @(negedge Clock);
    chk({name, " rsp_valid cleared"}, rvld(v.k), 0);
    set_rsp_ready(0, 1'b0);
    set_rsp_ready(1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          gk [4];
    int          gc [4];
    int          ng;
    logic [23:0] hold_m;
    logic [7:0]  hold_e;
    logic        stable;

    vecs[0]  = '{0, 24'h000001, 8'h40, 1'b1, 1'b0, 24'h000002, 8'h40, 1'b1, 1'b0};
    vecs[1]  = '{1, 24'h000002, 8'h40, 1'b1, 1'b0, 24'h000002, 8'h40, 1'b1, 1'b0};
    vecs[2]  = '{0, 24'h800000, 8'h20, 1'b0, 1'b0, 24'h800000, 8'h20, 1'b0, 1'b0};
    vecs[3]  = '{1, 24'h800000, 8'h20, 1'b0, 1'b1, 24'h800000, 8'h20, 1'b1, 1'b0};
    vecs[4]  = '{0, 24'h800001, 8'h21, 1'b1, 1'b1, 24'h800002, 8'h21, 1'b1, 1'b0};
    vecs[5]  = '{1, 24'hFFFFFF, 8'h10, 1'b1, 1'b1, 24'h800000, 8'h11, 1'b1, 1'b0};
    vecs[6]  = '{0, 24'hFFFFFF, 8'hFE, 1'b1, 1'b0, 24'h000000, 8'hFF, 1'b1, 1'b1};
    vecs[7]  = '{1, 24'hFFFFFF, 8'hFD, 1'b1, 1'b0, 24'h800000, 8'hFE, 1'b1, 1'b0};
    vecs[8]  = '{0, 24'hFFFFFF, 8'hFF, 1'b1, 1'b1, 24'h000000, 8'hFF, 1'b1, 1'b1};
    vecs[9]  = '{1, 24'hFFFFFF, 8'hFE, 1'b0, 1'b1, 24'hFFFFFF, 8'hFE, 1'b1, 1'b0};
    vecs[10] = '{0, 24'hABCDEF, 8'h7F, 1'b1, 1'b0, 24'hABCDF0, 8'h7F, 1'b1, 1'b0};

    drive_req(0, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    drive_req(1, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    set_rsp_ready(0, 1'b0);
    set_rsp_ready(1, 1'b0);

    // Reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    chk("reset rsp0_valid", bus.rsp0_valid, 0);
    chk("reset rsp1_valid", bus.rsp1_valid, 0);
    chk("reset rsp mant",   bus.rsp0_mant,  0);
    chk("reset rsp exp",    bus.rsp1_exp,   0);
    chk("reset flags", {30'd0, bus.rsp0_inexact, bus.rsp0_ovf}, 0);
    chk("reset ready idle", {30'd0, bus.req1_ready, bus.req0_ready}, 0);

    // First tie after reset goes to requester 0
    drive_req(0, 1'b1, 24'h000001, 8'h05, 1'b1, 1'b0);
    drive_req(1, 1'b1, 24'h123456, 8'h33, 1'b0, 1'b0);
    #1;
    chk("tie req0_ready", bus.req0_ready, 1);
    chk("tie req1_ready", bus.req1_ready, 0);
    @(posedge Clock);
    @(negedge Clock);
    drive_req(0, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    drive_req(1, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    @(negedge Clock);
    check_result(0, "tie", 24'h000002, 8'h05, 1'b1, 1'b0);
    set_rsp_ready(0, 1'b1);
    @(negedge Clock);
    chk("tie rsp0 consumed", bus.rsp0_valid, 0);
    set_rsp_ready(0, 1'b0);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Round-robin with both requesters valid; last grant was requester 0
    @(negedge Clock);
    drive_req(0, 1'b1, 24'h000004, 8'h01, 1'b0, 1'b0);
    drive_req(1, 1'b1, 24'h000008, 8'h02, 1'b0, 1'b0);
    set_rsp_ready(0, 1'b1);
    set_rsp_ready(1, 1'b1);
    ng = 0;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        gk[ng] = bus.req1_ready ? 1 : 0;
        gc[ng] = c;
        ng++;
      end
      @(negedge Clock);
    end
    drive_req(0, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    drive_req(1, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    chk("rr grant count", ng, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) begin
        chk($sformatf("rr grant%0d", i), gk[i], (i % 2 == 0) ? 1 : 0);
        if (i > 0) chk($sformatf("rr spacing%0d", i), gc[i] - gc[i-1], 3);
      end
    end
    repeat (3) @(negedge Clock);
    set_rsp_ready(0, 1'b0);
    set_rsp_ready(1, 1'b0);

    // Backpressure on requester 1 with requester 0 pending
    @(negedge Clock);
    drive_req(1, 1'b1, 24'h400001, 8'h22, 1'b1, 1'b1);
    wait_ready(1, "bp");
    @(posedge Clock);
    @(negedge Clock);
    drive_req(1, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    drive_req(0, 1'b1, 24'h000010, 8'h01, 1'b0, 1'b0);
    @(negedge Clock);
    check_result(1, "bp", 24'h400002, 8'h22, 1'b1, 1'b0);
    hold_m = bus.rsp1_mant;
    hold_e = bus.rsp1_exp;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock); #1;
      stable = bus.rsp1_valid && (bus.rsp1_mant == hold_m) && (bus.rsp1_exp == hold_e)
               && bus.rsp1_inexact && !bus.rsp1_ovf;
      chk($sformatf("bp hold%0d stable", c), stable, 1);
      chk($sformatf("bp hold%0d readies", c), {30'd0, bus.req1_ready, bus.req0_ready}, 0);
    end
    set_rsp_ready(1, 1'b1);
    @(negedge Clock); #1;
    set_rsp_ready(1, 1'b0);
    chk("bp rsp1 consumed", bus.rsp1_valid, 0);
    chk("bp req0 now ready", bus.req0_ready, 1);
    @(posedge Clock);
    @(negedge Clock);
    drive_req(0, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    @(negedge Clock);
    check_result(0, "bp req0", 24'h000010, 8'h01, 1'b0, 1'b0);
    set_rsp_ready(0, 1'b1);
    @(negedge Clock);
    set_rsp_ready(0, 1'b0);

    // Reset during ROUND discards the operation and restores tie priority
    drive_req(1, 1'b1, 24'h000005, 8'h09, 1'b1, 1'b0);
    wait_ready(1, "rst");
    @(posedge Clock);
    @(negedge Clock);
    drive_req(1, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    Reset = 1'b1;
    set_rsp_ready(1, 1'b1);
    @(negedge Clock);
    Reset = 1'b0;
    set_rsp_ready(1, 1'b0);
    chk("rst rsp1_valid", bus.rsp1_valid, 0);
    chk("rst rsp0_valid", bus.rsp0_valid, 0);
    chk("rst rsp mant", bus.rsp1_mant, 0);
    @(negedge Clock);
    chk("rst no late rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 0);
    drive_req(0, 1'b1, 24'h000007, 8'h03, 1'b0, 1'b0);
    drive_req(1, 1'b1, 24'h000009, 8'h04, 1'b0, 1'b0);
    #1;
    chk("rst tie req0_ready", bus.req0_ready, 1);
    chk("rst tie req1_ready", bus.req1_ready, 0);
    @(posedge Clock);
    @(negedge Clock);
    drive_req(0, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    drive_req(1, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0);
    @(negedge Clock);
    check_result(0, "rst tie", 24'h000007, 8'h03, 1'b0, 1'b0);
    set_rsp_ready(0, 1'b1);
    @(negedge Clock);
    set_rsp_ready(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
